digit_scan_ctrl: RTL



---
 rtl/scan_pkg.sv | 20 ++
 rtl/scan_prescaler.sv | 38 +++
 rtl/digit_scan_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared widths and helpers for the 4-digit scan controller.
// Imported by scan_prescaler and digit_scan_ctrl.
package scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam int NIB_W      = 4;
    localparam int VALUE_W    = NUM_DIGITS * NIB_W;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    // Pick nibble idx out of a packed display word.
    function automatic logic [NIB_W-1:0] get_nibble(
        input logic [VALUE_W-1:0] word,
        input logic [SEL_W-1:0]   idx
    );
        return word[NIB_W*idx +: NIB_W];
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Per-slot prescaler: counts 0..DIV-1 while enabled, freezes otherwise.
// tick marks the last cycle of a slot while scanning is enabled.
module scan_prescaler #(
    parameter int DIV   = 50000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last;

    assign last = (cnt_q == LAST);
    assign tick = last && en;
    assign cnt  = cnt_q;

    // Next count: wrap at end of slot, hold while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with frame-synchronous buffers.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (1..3).
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [VALUE_W-1:0] value,
    output logic [SEL_W-1:0]   sel,
    output logic [NIB_W-1:0]   nibble,
    output logic               blank,
    output logic               frame_done
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic               boundary;
    logic               lzb;

    logic [SEL_W-1:0]   sel_q,     sel_d;
    logic [VALUE_W-1:0] pending_q, pending_d;
    logic [VALUE_W-1:0] active_q,  active_d;
    logic               fdone_q,   fdone_d;

    scan_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cnt  (cnt),
        .tick (tick)
    );

    assign boundary = tick && (sel_q == LAST_SEL);

    // Digit advance, buffer transfer (with load bypass) and frame pulse.
    always_comb begin
        sel_d     = sel_q;
        pending_d = pending_q;
        active_d  = active_q;
        fdone_d   = 1'b0;
        if (load) begin
            pending_d = value;
        end
        if (tick) begin
            sel_d = sel_q + 1'b1;
        end
        if (boundary) begin
            active_d = load ? value : pending_q;
            fdone_d  = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            fdone_q   <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            fdone_q   <= fdone_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [VALUE_W-1:0] upper;

    // Blank digit sel when it and every higher digit are zero.
    always_comb begin
        upper = active_q >> (NIB_W * sel_q);
        lzb   = (sel_q != '0) && (upper == '0);
    end
`else
    assign lzb = 1'b0;
`endif

    assign sel        = sel_q;
    assign nibble     = get_nibble(active_q, sel_q);
    assign blank      = !en || (cnt < BLANK_C) || lzb;
    assign frame_done = fdone_q;

endmodule
